// File: rtl/framing_pkg.sv
// Shared framing constants: arbiter state codes, payload limit, overhead, EOF.
package framing_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam int MAX_PAYLOAD_DEF = 58;
    localparam int FRAME_OVERHEAD  = 5;

    localparam logic [7:0] EOF_CHAR = 8'h7e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx
);

    logic          found;
    logic [PW-1:0] j;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = PW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req[j]) begin
                win[j]  = 1'b1;
                win_idx = j;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/send_arbiter.sv
// Round-robin message arbiter feeding the framing ring and length fifo.
// Optional grant watchdog: define SEND_ARBITER_WATCHDOG_EN.
module send_arbiter
    import framing_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int LEN_BITS    = 8,
    parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF,
    parameter int WD_CYCLES   = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     grant,
    input  logic [NREQ*8-1:0]   req_data,
    input  logic [NREQ-1:0]     req_wr_en,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_end,
    output logic [7:0]          send_ring_data,
    output logic                send_ring_wr_en,
    input  logic                send_ring_full,
    output logic [LEN_BITS-1:0] send_fifo_data,
    output logic                send_fifo_wr_en,
    input  logic                send_fifo_full,
    output logic                error,
    input  logic                clr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]          state;
    logic [LEN_BITS-1:0] count;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       gidx;
    logic [NREQ-1:0]     win;
    logic [PW-1:0]       win_idx;

    logic streaming, committing;
    logic g_wr, g_end, room, open;
    logic accept, overflow, fifo_go, wd_fire;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    assign streaming  = (state == ST_STREAM);
    assign committing = (state == ST_COMMIT);
    assign g_wr       = |(grant & req_wr_en);
    assign g_end      = |(grant & req_end);
    assign room       = (count < LEN_BITS'(MAX_PAYLOAD));

    // An end strobe wins over a same-cycle byte, so the lane is not ready then.
    assign open      = streaming & !send_ring_full & !g_end;
    assign req_ready = (open & room) ? grant : '0;
    assign accept    = open & room & g_wr;
    assign overflow  = open & !room & g_wr;

    always_comb begin
        send_ring_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) send_ring_data = req_data[i*8 +: 8];
        end
    end

    assign send_ring_wr_en = accept;
    assign fifo_go         = committing & !send_fifo_full;
    assign send_fifo_wr_en = fifo_go;
    assign send_fifo_data  = committing ? count : '0;

`ifdef SEND_ARBITER_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES + 1);

    logic [WW-1:0] wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (!streaming || accept || send_ring_full) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    assign wd_fire = streaming & !accept & !send_ring_full & !g_end &
                     (wd == WW'(WD_CYCLES - 1));
`else
    assign wd_fire = (WD_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            gidx   <= '0;
            count  <= '0;
            rr_ptr <= '0;
            error  <= 1'b0;
        end else begin
            if (overflow || wd_fire) begin
                error <= 1'b1;
            end else if (clr) begin
                error <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant <= win;
                        gidx  <= win_idx;
                        count <= '0;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept) count <= count + 1'b1;
                    if (g_end || wd_fire) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (fifo_go) begin
                        grant  <= '0;
                        rr_ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_send_arbiter.sv
// Scoreboard bench for send_arbiter: directed messages, queue-checked outputs.
module tb_send_arbiter;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0] req_wr_en;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] req_end;
    logic [7:0]      send_ring_data;
    logic            send_ring_wr_en;
    logic            send_ring_full;
    logic [7:0]      send_fifo_data;
    logic            send_fifo_wr_en;
    logic            send_fifo_full;
    logic            error;
    logic            clr;

    logic [7:0] ring_q[$];
    logic [7:0] len_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    send_arbiter #(
        .NREQ(NREQ), .LEN_BITS(8), .MAX_PAYLOAD(58), .WD_CYCLES(16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .grant           (grant),
        .req_data        (req_data),
        .req_wr_en       (req_wr_en),
        .req_ready       (req_ready),
        .req_end         (req_end),
        .send_ring_data  (send_ring_data),
        .send_ring_wr_en (send_ring_wr_en),
        .send_ring_full  (send_ring_full),
        .send_fifo_data  (send_fifo_data),
        .send_fifo_wr_en (send_fifo_wr_en),
        .send_fifo_full  (send_fifo_full),
        .error           (error),
        .clr             (clr)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop expected bytes/lengths whenever the DUT writes.
    always @(negedge clk) begin
        if (send_ring_wr_en) begin
            total++;
            if (ring_q.size() == 0) begin
                bad++;
                $display("FAIL ring_unexpected: got %0h want none", send_ring_data);
            end else begin
                total--;
                chk("ring_byte", send_ring_data, ring_q.pop_front());
            end
        end
        if (send_fifo_wr_en) begin
            total++;
            if (len_q.size() == 0) begin
                bad++;
                $display("FAIL len_unexpected: got %0d want none", send_fifo_data);
            end else begin
                total--;
                chk("fifo_len", send_fifo_data, len_q.pop_front());
            end
        end
        if (!$onehot0(grant)) chk("grant_onehot", grant, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        req            = '0;
        req_wr_en      = '0;
        req_end        = '0;
        req_data       = '0;
        send_ring_full = 1'b0;
        send_fifo_full = 1'b0;
        clr            = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int i);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = grant[i];
        end
        chk("grant_wait", ok, 1);
        tick();
    endtask

    task automatic send_byte(input int i, input logic [7:0] b);
        logic acc;
        ring_q.push_back(b);
        req_data[i*8 +: 8] = b;
        req_wr_en[i] = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready[i];
            tick();
        end
        if (!acc) chk("byte_timeout", acc, 1);
        req_wr_en[i] = 1'b0;
    endtask

    task automatic send_end(input int i, input logic [7:0] len);
        len_q.push_back(len);
        req_end[i] = 1'b1;
        tick();
        req_end[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ord [5] = '{0, 1, 2, 3, 0};

        // Reset state
        rst_n          = 1'b0;
        req            = '0;
        req_wr_en      = '0;
        req_end        = '0;
        req_data       = '0;
        send_ring_full = 1'b0;
        send_fifo_full = 1'b0;
        clr            = 1'b0;
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_error", error, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_ring_wr", send_ring_wr_en, 0);
        chk("rst_fifo_wr", send_fifo_wr_en, 0);
        chk("rst_fifo_data", send_fifo_data, 0);
        tick();
        rst_n = 1'b1;

        // Basic 3-byte message; ungranted lane 2 noise must be ignored
        req = 4'b0001;
        wait_grant(0);
        req_wr_en[2] = 1'b1;
        req_end[2]   = 1'b1;
        req_data[23:16] = 8'hee;
        send_byte(0, 8'h11);
        req_wr_en[2] = 1'b0;
        req_end[2]   = 1'b0;
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        send_end(0, 8'd3);
        req = '0;
        @(negedge clk);
        chk("t1_fifo_wr", send_fifo_wr_en, 1);
        chk("t1_fifo_data", send_fifo_data, 3);
        chk("t1_error", error, 0);
        tick();

        // Round-robin across all four held requesters
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                wait_grant(ord[k]);
            end else begin
                @(negedge clk);
                chk("rr_grant", grant, 32'd1 << ord[k]);
                tick();
            end
            send_byte(ord[k], 8'ha0 + 8'(k));
            if (k == 4) req = '0;
            send_end(ord[k], 8'd1);
            @(negedge clk);
            chk("rr_commit_hold", grant, 32'd1 << ord[k]);
            @(negedge clk);
            chk("rr_idle_gap", grant, 0);
        end
        tick();

        // Ring full stall for five cycles mid-message
        do_reset();
        req = 4'b0001;
        wait_grant(0);
        send_byte(0, 8'h01);
        send_byte(0, 8'h02);
        send_ring_full = 1'b1;
        req_data[7:0]  = 8'hbb;
        req_wr_en[0]   = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("full_ready", req_ready, 0);
            chk("full_ring_wr", send_ring_wr_en, 0);
            tick();
        end
        req_wr_en[0]   = 1'b0;
        send_ring_full = 1'b0;
        send_byte(0, 8'h03);
        send_byte(0, 8'h04);
        send_end(0, 8'd4);
        req = '0;
        @(negedge clk);
        chk("full_error", error, 0);
        tick();

        // Overflow: 58 accepted, 59th dropped with error, then clr
        do_reset();
        req = 4'b0010;
        wait_grant(1);
        for (int b = 0; b < 58; b++) send_byte(1, 8'(b + 1));
        req_data[15:8] = 8'hff;
        req_wr_en[1]   = 1'b1;
        @(negedge clk);
        chk("ovf_ready", req_ready, 0);
        chk("ovf_ring_wr", send_ring_wr_en, 0);
        tick();
        chk("ovf_error", error, 1);
        req_wr_en[1] = 1'b0;
        send_end(1, 8'd58);
        req = '0;
        tick();
        chk("ovf_sticky", error, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_error", error, 0);

        // Zero-byte message commits length 0
        req = 4'b0100;
        wait_grant(2);
        send_end(2, 8'd0);
        req = '0;
        tick();
        tick();

        // Length fifo full stalls the commit
        do_reset();
        req = 4'b1000;
        wait_grant(3);
        send_byte(3, 8'h5a);
        send_fifo_full = 1'b1;
        send_end(3, 8'd1);
        req = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("ffull_no_wr", send_fifo_wr_en, 0);
            chk("ffull_grant", grant, 4'b1000);
        end
        tick();
        send_fifo_full = 1'b0;
        @(negedge clk);
        chk("ffull_release", send_fifo_wr_en, 1);
        @(negedge clk);
        chk("ffull_grant_off", grant, 0);
        tick();

        // Reset mid-message abandons it without a length write
        req = 4'b0100;
        wait_grant(2);
        send_byte(2, 8'h77);
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_ready", req_ready, 0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();

`ifdef SEND_ARBITER_WATCHDOG_EN
        // Watchdog: two bytes then silence
        begin
            int cyc;
            logic seen;
            req = 4'b0001;
            wait_grant(0);
            send_byte(0, 8'hc1);
            send_byte(0, 8'hc2);
            len_q.push_back(8'd2);
            cyc  = 0;
            seen = 1'b0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                cyc++;
                seen = send_fifo_wr_en;
            end
            chk("wd_commit", seen, 1);
            chk("wd_window", (cyc >= 14 && cyc <= 18), 1);
            chk("wd_error", error, 1);
            req = '0;
            tick();
        end
`endif

        repeat (3) @(negedge clk);
        chk("ring_q_empty", ring_q.size(), 0);
        chk("len_q_empty", len_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/send_arbiter.md
SEND_ARBITER -- requirements
Module: send_arbiter

Interface
REQ-001 SHALL have parameters: NREQ, default 4, number of requesters; LEN_BITS, default 8, length width (matches framing send length fifo); MAX_PAYLOAD, default 58, max payload bytes per frame; WD_CYCLES, default 4096, watchdog limit.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req  in  NREQ  per-requester message request, level, held until end.
REQ-005 SHALL have ports: grant  out  NREQ  one-hot registered grant.
REQ-006 SHALL have ports: req_data  in  NREQ*8  payload byte per requester, slice i = bits [8i+7:8i].
REQ-007 SHALL have ports: req_wr_en  in  NREQ  byte strobe per requester.
REQ-008 SHALL have ports: req_ready  out  NREQ  combinational; byte accepted when wr_en & ready.
REQ-009 SHALL have ports: req_end  in  NREQ  single-cycle end-of-message strobe, no data.
REQ-010 SHALL have ports: send_ring_data  out  8, send_ring_wr_en  out  1, send_ring_full  in  1  to framing ring.
REQ-011 SHALL have ports: send_fifo_data  out  LEN_BITS, send_fifo_wr_en  out  1, send_fifo_full  in  1  to framing length fifo.
REQ-012 SHALL have ports: error  out  1  sticky; clr  in  1  synchronous clear of error.

Function
REQ-013 SHALL implement states IDLE, STREAM, COMMIT.
REQ-014 IDLE: any req bit set -> grant round-robin winner (search from rr_ptr upward, wrap) next cycle, byte count := 0, -> STREAM.
REQ-015 STREAM: req_ready[i] = grant[i] & !send_ring_full & (count < MAX_PAYLOAD); all others 0.
REQ-016 STREAM: accepted byte drives send_ring_data/send_ring_wr_en combinationally same cycle; count increments by 1.
REQ-017 STREAM: wr_en from granted requester with count == MAX_PAYLOAD and ring not full -> byte dropped, error := 1.
REQ-018 STREAM: wr_en and ready deasserted (ring full) -> no write, no count change, no error.
REQ-019 STREAM: req_end from granted requester -> COMMIT next cycle; same-cycle wr_en ignored.
REQ-020 STREAM: req_end and wr_en from ungranted requesters SHALL be ignored.
REQ-021 COMMIT: when !send_fifo_full, send_fifo_wr_en = 1 for one cycle with send_fifo_data = count, grant := 0, rr_ptr := winner+1 mod NREQ, -> IDLE.
REQ-022 COMMIT: send_fifo_full stalls in COMMIT, no write, grant held.
REQ-023 Zero-byte message (end with count 0) SHALL commit length 0.
REQ-024 Minimum gap between grants is one IDLE cycle; at most one grant set at any time.
REQ-025 Requester dropping req in STREAM without end SHALL not terminate the message (watchdog only, REQ-030).
REQ-026 clr SHALL clear error only; simultaneous clr and new error -> error = 1.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, grant 0, count 0, rr_ptr 0, error 0, send_ring_wr_en 0, send_fifo_wr_en 0, send_fifo_data 0, req_ready 0.
REQ-028 Reset mid-message SHALL abandon it with no length write; ring bytes already written are the caller's responsibility (framing reset together).

Configuration
REQ-029 Macro SEND_ARBITER_WATCHDOG_EN SHALL gate the grant watchdog.
REQ-030 With it: idle counter reset on each accepted byte or stall-by-full; reaching WD_CYCLES in STREAM -> forced COMMIT with current count, error := 1.
REQ-031 Without it: no counter logic; STREAM held indefinitely.

Structure
REQ-032 Shared package framing_pkg SHALL hold state encodings, MAX_PAYLOAD default 58, frame overhead 5, EOF char 8'h7e.
REQ-033 Sub-module rr_arbiter (NREQ, req + rr_ptr -> one-hot winner, combinational) SHALL perform the pick.

Verification
REQ-034 req=0001, 3 bytes 11,22,33, end -> ring gets 11,22,33 in order; fifo_data=3 one cycle after end.
REQ-035 req=1111 held, each sends 1 byte -> grants 0,1,2,3,0 in order, one IDLE cycle between.
REQ-036 ring_full high 5 cycles mid-message -> ready 0, no writes, count unchanged, resumes, error 0.
REQ-037 59 bytes -> 58 written, 59th dropped, error=1, fifo_data=58; clr -> error 0.
REQ-038 fifo_full during COMMIT 10 cycles -> fifo_wr_en only after release, grant held throughout.
REQ-039 WATCHDOG_EN, WD_CYCLES=16, 2 bytes then silence -> forced commit len 2 at cycle 16, error=1.
